// File: rtl/triangle_feeder.sv
`default_nettype none
// =============================================================================
// triangle_feeder: vertex FIFO replaying A,B,C triplets on the 8-slot schedule
// Revision: 1.0
// =============================================================================
module triangle_feeder #(
  parameter int DEPTH = 8,
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_x,
  input  logic [8:0]  in_y,
  input  logic        flush,
  output logic [9:0]  out_x,
  output logic [8:0]  out_y,
  output logic        out_enable,
  output logic [2:0]  out_slot,
  output logic        tri_start,
  output logic        res_valid,
  output logic        clip_err,
  output logic [15:0] tri_cnt
);

  localparam int                c_aw      = $clog2(DEPTH);
  localparam logic [c_aw-1:0]   c_ptr_one = c_aw'(1);
  localparam logic [c_aw:0]     c_cnt_one = (c_aw + 1)'(1);
  localparam logic [c_aw:0]     c_min_occ = (c_aw + 1)'(3);
  localparam logic [c_aw:0]     c_full    = (c_aw + 1)'(DEPTH);
  localparam logic [9:0]        c_x_max   = 10'(X_MAX);
  localparam logic [8:0]        c_y_max   = 9'(Y_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1
  } frame_state_t;

  logic [2:0]      r_slot;
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_aw:0]   r_count;
  logic [9:0]      r_mem_x [DEPTH];
  logic [8:0]      r_mem_y [DEPTH];
  frame_state_t    r_state;
  logic            r_done;
  logic            r_clip;
  logic [15:0]     r_tri_cnt;

  logic       w_slot0;
  logic       w_issue;
  logic       w_active;
  logic       w_head_phase;
  logic       w_push;
  logic       w_pop;
  logic       w_clip;
  logic [9:0] w_x;
  logic [8:0] w_y;

  assign w_slot0  = (r_slot == 3'd0);
  // The issue decision only sees occupancy registered before slot 0.
  assign w_issue  = w_slot0 && (r_count >= c_min_occ);
  assign w_active = w_slot0 ? w_issue : (r_state == ST_ISSUE);
  assign w_head_phase = w_active && (r_slot <= 3'd2);

  assign in_ready = (r_count != c_full);
  assign w_push   = in_valid && in_ready && !flush;
  assign w_pop    = w_issue ||
                    ((r_state == ST_ISSUE) && ((r_slot == 3'd1) || (r_slot == 3'd2)));

  assign w_clip = (in_x > c_x_max) || (in_y > c_y_max);
  assign w_x    = (in_x > c_x_max) ? c_x_max : in_x;
  assign w_y    = (in_y > c_y_max) ? c_y_max : in_y;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wptr] <= w_x;
      r_mem_y[r_wptr] <= w_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot    <= 3'd0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_state   <= ST_IDLE;
      r_done    <= 1'b0;
      r_clip    <= 1'b0;
      r_tri_cnt <= 16'd0;
    end else begin
      r_slot <= r_slot + 3'd1;
      if (w_push && w_clip) r_clip <= 1'b1;
      if (w_issue) r_tri_cnt <= r_tri_cnt + 16'd1;

      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + c_ptr_one;
        if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_cnt_one;
          2'b01:   r_count <= r_count - c_cnt_one;
          default: r_count <= r_count;
        endcase
      end

      // A flush kills the in-flight frame and the result it would have produced.
      if (w_slot0)
        r_state <= (w_issue && !flush) ? ST_ISSUE : ST_IDLE;
      else if (flush)
        r_state <= ST_IDLE;

      if (r_slot == 3'd7)
        r_done <= (r_state == ST_ISSUE) && !flush;
    end
  end

  assign out_x      = w_head_phase ? r_mem_x[r_rptr] : 10'd0;
  assign out_y      = w_head_phase ? r_mem_y[r_rptr] : 9'd0;
  assign out_enable = w_active;
  assign out_slot   = r_slot;
  assign tri_start  = w_issue;
  assign res_valid  = w_slot0 && r_done;
  assign clip_err   = r_clip;
  assign tri_cnt    = r_tri_cnt;

endmodule
`default_nettype wire

// File: tb/tb_triangle_feeder.sv
`default_nettype none
// =============================================================================
// tb_triangle_feeder: directed self-checking bench for triangle_feeder
// Revision: 1.0
// =============================================================================
module tb_triangle_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_x;
  logic [8:0]  in_y;
  logic        flush;
  logic [9:0]  out_x;
  logic [8:0]  out_y;
  logic        out_enable;
  logic [2:0]  out_slot;
  logic        tri_start;
  logic        res_valid;
  logic        clip_err;
  logic [15:0] tri_cnt;

  int         n_chk = 0;
  int         n_err = 0;
  logic [2:0] es = 3'd0;

  always #5 clk = ~clk;

  triangle_feeder #(.DEPTH(8), .X_MAX(639), .Y_MAX(479)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .flush(flush), .out_x(out_x), .out_y(out_y),
    .out_enable(out_enable), .out_slot(out_slot), .tri_start(tri_start),
    .res_valid(res_valid), .clip_err(clip_err), .tri_cnt(tri_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    es = es + 3'd1;
  endtask

  task automatic push(input logic [9:0] x, input logic [8:0] y);
    in_valid = 1'b1; in_x = x; in_y = y;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic goto_slot(input logic [2:0] s);
    while (es != s) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_x = '0; in_y = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    es = 3'd0;
    n_chk++; if (out_slot !== 3'd0) begin n_err++; $display("FAIL rst_slot: got %0d want 0", out_slot); end
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b want 1", in_ready); end
    n_chk++; if (out_enable !== 1'b0) begin n_err++; $display("FAIL rst_enable: got %0b want 0", out_enable); end
    n_chk++; if (out_x !== 10'd0 || out_y !== 9'd0) begin n_err++; $display("FAIL rst_xy: got %0d,%0d want 0,0", out_x, out_y); end
    n_chk++; if (tri_start !== 1'b0 || res_valid !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got %0b,%0b want 0,0", tri_start, res_valid); end
    n_chk++; if (clip_err !== 1'b0) begin n_err++; $display("FAIL rst_clip: got %0b want 0", clip_err); end
    n_chk++; if (tri_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", tri_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    push(10'd10, 9'd20); push(10'd30, 9'd40); push(10'd50, 9'd60);
    goto_slot(3'd0);
    n_chk++; if (out_slot !== 3'd0) begin n_err++; $display("FAIL b_slot0: got %0d want 0", out_slot); end
    n_chk++; if (out_enable !== 1'b1 || tri_start !== 1'b1) begin n_err++; $display("FAIL b_issue: got en=%0b ts=%0b want 1,1", out_enable, tri_start); end
    n_chk++; if (out_x !== 10'd10 || out_y !== 9'd20) begin n_err++; $display("FAIL b_A: got %0d,%0d want 10,20", out_x, out_y); end
    n_chk++; if (tri_cnt !== 16'd0 || res_valid !== 1'b0) begin n_err++; $display("FAIL b_cnt0: got cnt=%0d rv=%0b want 0,0", tri_cnt, res_valid); end
    tick();
    n_chk++; if (out_x !== 10'd30 || out_y !== 9'd40) begin n_err++; $display("FAIL b_B: got %0d,%0d want 30,40", out_x, out_y); end
    n_chk++; if (tri_cnt !== 16'd1 || tri_start !== 1'b0) begin n_err++; $display("FAIL b_cnt1: got cnt=%0d ts=%0b want 1,0", tri_cnt, tri_start); end
    tick();
    n_chk++; if (out_x !== 10'd50 || out_y !== 9'd60) begin n_err++; $display("FAIL b_C: got %0d,%0d want 50,60", out_x, out_y); end
    for (int i = 3; i < 8; i++) begin
      tick();
      n_chk++; if (out_slot !== 3'(i)) begin n_err++; $display("FAIL b_slot%0d: got %0d", i, out_slot); end
      n_chk++; if (out_enable !== 1'b1 || out_x !== 10'd0 || out_y !== 9'd0 || res_valid !== 1'b0)
        begin n_err++; $display("FAIL b_compute%0d: got en=%0b x=%0d y=%0d rv=%0b want 1,0,0,0", i, out_enable, out_x, out_y, res_valid); end
    end
    tick();
    n_chk++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL b_res: got %0b want 1", res_valid); end
    n_chk++; if (out_enable !== 1'b0 || tri_start !== 1'b0) begin n_err++; $display("FAIL b_next_idle: got en=%0b ts=%0b want 0,0", out_enable, tri_start); end
  endtask

  task automatic test_partial();
    push(10'd100, 9'd200); push(10'd110, 9'd210);
    goto_slot(3'd0);
    n_chk++; if (out_enable !== 1'b0 || tri_start !== 1'b0 || res_valid !== 1'b0)
      begin n_err++; $display("FAIL p_idle: got en=%0b ts=%0b rv=%0b want 0,0,0", out_enable, tri_start, res_valid); end
    push(10'd120, 9'd220);
    for (int i = 1; i < 8; i++) begin
      n_chk++; if (out_enable !== 1'b0 || out_x !== 10'd0) begin n_err++; $display("FAIL p_idle_slot%0d: got en=%0b x=%0d want 0,0", i, out_enable, out_x); end
      tick();
    end
    n_chk++; if (out_enable !== 1'b1 || tri_start !== 1'b1 || out_x !== 10'd100 || out_y !== 9'd200)
      begin n_err++; $display("FAIL p_issue: got en=%0b ts=%0b x=%0d y=%0d want 1,1,100,200", out_enable, tri_start, out_x, out_y); end
    tick();
    n_chk++; if (out_x !== 10'd110 || tri_cnt !== 16'd2) begin n_err++; $display("FAIL p_B: got x=%0d cnt=%0d want 110,2", out_x, tri_cnt); end
    tick();
    n_chk++; if (out_x !== 10'd120 || out_y !== 9'd220) begin n_err++; $display("FAIL p_C: got %0d,%0d want 120,220", out_x, out_y); end
    goto_slot(3'd0);
    n_chk++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL p_res: got %0b want 1", res_valid); end
  endtask

  task automatic test_clamp();
    push(10'd639, 9'd479);
    n_chk++; if (clip_err !== 1'b0) begin n_err++; $display("FAIL c_edge: got %0b want 0", clip_err); end
    push(10'd700, 9'd500);
    n_chk++; if (clip_err !== 1'b1) begin n_err++; $display("FAIL c_set: got %0b want 1", clip_err); end
    push(10'd640, 9'd10);
    goto_slot(3'd0);
    n_chk++; if (out_x !== 10'd639 || out_y !== 9'd479) begin n_err++; $display("FAIL c_A: got %0d,%0d want 639,479", out_x, out_y); end
    tick();
    n_chk++; if (out_x !== 10'd639 || out_y !== 9'd479) begin n_err++; $display("FAIL c_B: got %0d,%0d want 639,479", out_x, out_y); end
    tick();
    n_chk++; if (out_x !== 10'd639 || out_y !== 9'd10) begin n_err++; $display("FAIL c_C: got %0d,%0d want 639,10", out_x, out_y); end
    goto_slot(3'd0);
    n_chk++; if (clip_err !== 1'b1 || res_valid !== 1'b1 || tri_cnt !== 16'd3)
      begin n_err++; $display("FAIL c_sticky: got clip=%0b rv=%0b cnt=%0d want 1,1,3", clip_err, res_valid, tri_cnt); end
  endtask

  task automatic test_full();
    tick();
    push(10'd1, 9'd2); push(10'd11, 9'd12);
    goto_slot(3'd0);
    n_chk++; if (out_enable !== 1'b0) begin n_err++; $display("FAIL f_idle: got %0b want 0", out_enable); end
    for (int i = 2; i < 8; i++) begin
      n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL f_ready%0d: got %0b want 1", i, in_ready); end
      push(10'(i * 10 + 1), 9'(i * 10 + 2));
    end
    n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL f_full: got %0b want 0", in_ready); end
    push(10'd77, 9'd77);
    n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL f_full_hold: got %0b want 0", in_ready); end
    tick();
    n_chk++; if (out_enable !== 1'b1 || out_x !== 10'd1 || out_y !== 9'd2 || in_ready !== 1'b0)
      begin n_err++; $display("FAIL f_issue: got en=%0b x=%0d y=%0d rdy=%0b want 1,1,2,0", out_enable, out_x, out_y, in_ready); end
    tick();
    n_chk++; if (in_ready !== 1'b1 || out_x !== 10'd11) begin n_err++; $display("FAIL f_after_pop: got rdy=%0b x=%0d want 1,11", in_ready, out_x); end
    tick();
    n_chk++; if (out_x !== 10'd21) begin n_err++; $display("FAIL f_C: got %0d want 21", out_x); end
    goto_slot(3'd0);
    n_chk++; if (out_enable !== 1'b1 || res_valid !== 1'b1 || out_x !== 10'd31)
      begin n_err++; $display("FAIL f_second: got en=%0b rv=%0b x=%0d want 1,1,31", out_enable, res_valid, out_x); end
    tick();
    n_chk++; if (out_x !== 10'd41) begin n_err++; $display("FAIL f_second_B: got %0d want 41", out_x); end
    tick();
    n_chk++; if (out_x !== 10'd51) begin n_err++; $display("FAIL f_second_C: got %0d want 51", out_x); end
    goto_slot(3'd0);
    n_chk++; if (out_enable !== 1'b0 || res_valid !== 1'b1 || tri_cnt !== 16'd5)
      begin n_err++; $display("FAIL f_left2: got en=%0b rv=%0b cnt=%0d want 0,1,5", out_enable, res_valid, tri_cnt); end
  endtask

  task automatic test_flush();
    push(10'd300, 9'd301);
    goto_slot(3'd0);
    n_chk++; if (out_enable !== 1'b1 || out_x !== 10'd61) begin n_err++; $display("FAIL fl_issue: got en=%0b x=%0d want 1,61", out_enable, out_x); end
    tick();
    n_chk++; if (out_x !== 10'd71 || tri_cnt !== 16'd6) begin n_err++; $display("FAIL fl_B: got x=%0d cnt=%0d want 71,6", out_x, tri_cnt); end
    flush = 1'b1; in_valid = 1'b1; in_x = 10'd88; in_y = 9'd88;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (out_enable !== 1'b0 || out_x !== 10'd0 || out_y !== 9'd0)
      begin n_err++; $display("FAIL fl_kill: got en=%0b x=%0d y=%0d want 0,0,0", out_enable, out_x, out_y); end
    n_chk++; if (in_ready !== 1'b1 || tri_cnt !== 16'd6) begin n_err++; $display("FAIL fl_state: got rdy=%0b cnt=%0d want 1,6", in_ready, tri_cnt); end
    push(10'd400, 9'd401); push(10'd410, 9'd411);
    while (es != 3'd0) begin
      n_chk++; if (out_enable !== 1'b0) begin n_err++; $display("FAIL fl_off_slot%0d: got %0b want 0", es, out_enable); end
      tick();
    end
    n_chk++; if (res_valid !== 1'b0 || out_enable !== 1'b0 || tri_start !== 1'b0)
      begin n_err++; $display("FAIL fl_after: got rv=%0b en=%0b ts=%0b want 0,0,0", res_valid, out_enable, tri_start); end
  endtask

  task automatic test_back_to_back();
    push(10'd420, 9'd421); push(10'd430, 9'd431); push(10'd440, 9'd441); push(10'd450, 9'd451);
    goto_slot(3'd0);
    n_chk++; if (tri_start !== 1'b1 || res_valid !== 1'b0 || out_x !== 10'd400 || tri_cnt !== 16'd6)
      begin n_err++; $display("FAIL bb_f1: got ts=%0b rv=%0b x=%0d cnt=%0d want 1,0,400,6", tri_start, res_valid, out_x, tri_cnt); end
    tick();
    n_chk++; if (out_x !== 10'd410 || tri_cnt !== 16'd7) begin n_err++; $display("FAIL bb_f1_B: got x=%0d cnt=%0d want 410,7", out_x, tri_cnt); end
    tick();
    n_chk++; if (out_x !== 10'd420) begin n_err++; $display("FAIL bb_f1_C: got %0d want 420", out_x); end
    goto_slot(3'd0);
    n_chk++; if (tri_start !== 1'b1 || res_valid !== 1'b1 || out_x !== 10'd430 || out_y !== 9'd431)
      begin n_err++; $display("FAIL bb_f2: got ts=%0b rv=%0b x=%0d y=%0d want 1,1,430,431", tri_start, res_valid, out_x, out_y); end
    tick();
    n_chk++; if (out_x !== 10'd440 || tri_cnt !== 16'd8) begin n_err++; $display("FAIL bb_f2_B: got x=%0d cnt=%0d want 440,8", out_x, tri_cnt); end
    tick();
    n_chk++; if (out_x !== 10'd450) begin n_err++; $display("FAIL bb_f2_C: got %0d want 450", out_x); end
    goto_slot(3'd0);
    n_chk++; if (out_enable !== 1'b0 || res_valid !== 1'b1 || tri_cnt !== 16'd8)
      begin n_err++; $display("FAIL bb_f3: got en=%0b rv=%0b cnt=%0d want 0,1,8", out_enable, res_valid, tri_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    push(10'd1, 9'd1); push(10'd2, 9'd2); push(10'd3, 9'd3);
    goto_slot(3'd0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    es = 3'd0;
    n_chk++; if (out_slot !== 3'd0 || out_enable !== 1'b0 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL rm_state: got slot=%0d en=%0b rdy=%0b want 0,0,1", out_slot, out_enable, in_ready); end
    n_chk++; if (clip_err !== 1'b0 || tri_cnt !== 16'd0) begin n_err++; $display("FAIL rm_clear: got clip=%0b cnt=%0d want 0,0", clip_err, tri_cnt); end
    tick();
    goto_slot(3'd0);
    n_chk++; if (res_valid !== 1'b0 || out_enable !== 1'b0) begin n_err++; $display("FAIL rm_nores: got rv=%0b en=%0b want 0,0", res_valid, out_enable); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_clamp();
    test_full();
    test_flush();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
